// File: rtl/mem_lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit: operation codes,
// FSM state encoding, bus widths and the decode helpers the top level and the
// load aligner both rely on.
package mem_lsu_pkg;

    localparam int GPR_BUS      = 32;
    localparam int GPR_ADDR_BUS = 5;

    typedef enum logic [3:0] {
        MEM_OP_NONE = 4'd0,
        MEM_OP_LB   = 4'd1,
        MEM_OP_LBU  = 4'd2,
        MEM_OP_LH   = 4'd3,
        MEM_OP_LHU  = 4'd4,
        MEM_OP_LW   = 4'd5,
        MEM_OP_SB   = 4'd6,
        MEM_OP_SH   = 4'd7,
        MEM_OP_SW   = 4'd8
    } mem_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } lsu_state_e;

    function automatic logic is_load(mem_op_e op);
        return op inside {MEM_OP_LB, MEM_OP_LBU, MEM_OP_LH, MEM_OP_LHU, MEM_OP_LW};
    endfunction

    function automatic logic is_store(mem_op_e op);
        return op inside {MEM_OP_SB, MEM_OP_SH, MEM_OP_SW};
    endfunction

    // Halfword accesses need an even address, word accesses a multiple of four.
    function automatic logic misaligned(mem_op_e op, logic [1:0] offset);
        case (op)
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return offset[0];
            MEM_OP_LW, MEM_OP_SW:             return offset != 2'b00;
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data SRAM bus between the load/store unit (master) and the synchronous data
// SRAM (slave). wen of zero with en high is a read; rdata is valid a fixed
// number of cycles after the read strobe.
interface mem_lsu_if;
    import mem_lsu_pkg::*;

    logic               en;
    logic [3:0]         wen;
    logic [GPR_BUS-1:0] addr;
    logic [GPR_BUS-1:0] wdata;
    logic [GPR_BUS-1:0] rdata;

    modport master (
        output en,
        output wen,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  en,
        input  wen,
        input  addr,
        input  wdata,
        output rdata
    );

endinterface

// File: rtl/mem_load_align.sv
// Combinational load aligner: picks the addressed byte or halfword out of the
// SRAM read word and sign- or zero-extends it to a full register value.
module mem_load_align
    import mem_lsu_pkg::*;
(
    input  mem_op_e            op,
    input  logic [1:0]         offset,
    input  logic [GPR_BUS-1:0] rdata,
    output logic [GPR_BUS-1:0] data
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Select the addressed lane, then extend according to the load flavour.
    always_comb begin
        // NOTE: every variable written here gets a default first so no path through the case infers a latch.
        byte_val = 8'(rdata >> {offset, 3'b000});
        half_val = 16'(rdata >> {offset[1], 4'b0000});
        data     = rdata;
        case (op)
            MEM_OP_LB:  data = {{24{byte_val[7]}}, byte_val};
            MEM_OP_LBU: data = {24'h000000, byte_val};
            MEM_OP_LH:  data = {{16{half_val[15]}}, half_val};
            MEM_OP_LHU: data = {16'h0000, half_val};
            default:    data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit. Issues SRAM accesses for ex_mem, builds store byte
// lanes, flags misaligned accesses, and holds the pipeline with load_stall while
// load data is in flight. All mem_* outputs are combinational; mem_wb registers them.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int LOAD_LATENCY = 1
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    ex_valid,
    input  mem_op_e                 ex_mem_op,
    input  logic [GPR_BUS-1:0]      ex_addr,
    input  logic [GPR_BUS-1:0]      ex_store_data,
    input  logic [GPR_BUS-1:0]      ex_alu_result,
    input  logic                    ex_wreg_en,
    input  logic [GPR_ADDR_BUS-1:0] ex_wreg_addr,
    input  logic [GPR_BUS-1:0]      ex_pc,
    mem_lsu_if.master               sram,
    output logic                    load_stall,
    output logic                    mem_regfile_write_enable,
    output logic [GPR_ADDR_BUS-1:0] mem_regfile_write_addr,
    output logic [GPR_BUS-1:0]      mem_regfile_write_data,
    output logic [GPR_BUS-1:0]      mem_pc,
    output logic                    adel,
    output logic                    ades,
    output logic [GPR_BUS-1:0]      badvaddr
);

    if (LOAD_LATENCY < 1 || LOAD_LATENCY > 3) begin : g_bad_latency
        $error("mem_lsu: LOAD_LATENCY must be in 1..3");
    end

    // The counter holds the remaining wait cycles after the issue cycle.
    localparam logic [1:0] CNT_INIT = 2'(LOAD_LATENCY - 1);

    lsu_state_e              state;
    logic [1:0]              cnt;
    mem_op_e                 lat_op;
    logic [1:0]              lat_off;
    logic [GPR_ADDR_BUS-1:0] lat_wreg_addr;
    logic [GPR_BUS-1:0]      lat_pc;

    logic                    op_load;
    logic                    op_store;
    logic                    addr_err;
    logic [GPR_BUS-1:0]      word_addr;
    logic [3:0]              store_wen;
    logic [GPR_BUS-1:0]      store_wdata;
    logic [GPR_BUS-1:0]      load_data;

    assign op_load   = is_load(ex_mem_op);
    assign op_store  = is_store(ex_mem_op);
    assign addr_err  = misaligned(ex_mem_op, ex_addr[1:0]);
    assign word_addr = {ex_addr[GPR_BUS-1:2], 2'b00};

    // Aligner works on the latched op/offset so ex_* may move on once the load retires.
    mem_load_align u_align (
        .op     (lat_op),
        .offset (lat_off),
        .rdata  (sram.rdata),
        .data   (load_data)
    );

    // Store lane enables and replicated write data for the current ex_mem store.
    always_comb begin
        store_wen   = 4'b0000;
        store_wdata = ex_store_data;
        case (ex_mem_op)
            MEM_OP_SB: begin
                store_wen   = 4'b0001 << ex_addr[1:0];
                store_wdata = {4{ex_store_data[7:0]}};
            end
            MEM_OP_SH: begin
                store_wen   = ex_addr[1] ? 4'b1100 : 4'b0011;
                store_wdata = {2{ex_store_data[15:0]}};
            end
            MEM_OP_SW: begin
                store_wen   = 4'b1111;
                store_wdata = ex_store_data;
            end
            default: begin
                store_wen   = 4'b0000;
                store_wdata = ex_store_data;
            end
        endcase
    end

    // Load FSM: latch the load context on issue, count down the SRAM latency, retire.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= 2'd0;
            lat_op        <= MEM_OP_NONE;
            lat_off       <= 2'd0;
            lat_wreg_addr <= '0;
            lat_pc        <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
            cnt   <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ex_valid && op_load && !addr_err) begin
                        state         <= ST_WAIT;
                        cnt           <= CNT_INIT;
                        lat_op        <= ex_mem_op;
                        lat_off       <= ex_addr[1:0];
                        lat_wreg_addr <= ex_wreg_addr;
                        lat_pc        <= ex_pc;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 2'd0) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= 2'd0;
                end
            endcase
        end
    end

    // Output decode: SRAM strobes, stall, writeback and exception signals for this cycle.
    always_comb begin
        sram.en                  = 1'b0;
        sram.wen                 = 4'b0000;
        sram.addr                = '0;
        sram.wdata               = '0;
        load_stall               = 1'b0;
        mem_regfile_write_enable = 1'b0;
        mem_regfile_write_addr   = '0;
        mem_regfile_write_data   = '0;
        mem_pc                   = '0;
        adel                     = 1'b0;
        ades                     = 1'b0;
        badvaddr                 = '0;
        // Reset and flush both silence the unit in the same cycle they are seen.
        if (!rst && !flush) begin
            case (state)
                ST_IDLE: begin
                    if (ex_valid) begin
                        mem_pc = ex_pc;
                        if (addr_err) begin
                            adel     = op_load;
                            ades     = op_store;
                            badvaddr = ex_addr;
                        end else if (op_load) begin
                            sram.en    = 1'b1;
                            sram.addr  = word_addr;
                            load_stall = 1'b1;
                        end else if (op_store) begin
                            sram.en    = 1'b1;
                            sram.wen   = store_wen;
                            sram.addr  = word_addr;
                            sram.wdata = store_wdata;
                        end else begin
                            mem_regfile_write_enable = ex_wreg_en;
                            mem_regfile_write_addr   = ex_wreg_addr;
                            mem_regfile_write_data   = ex_alu_result;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt != 2'd0) begin
                        load_stall = 1'b1;
                    end else begin
                        mem_regfile_write_enable = 1'b1;
                        mem_regfile_write_addr   = lat_wreg_addr;
                        mem_regfile_write_data   = load_data;
                        mem_pc                   = lat_pc;
                    end
                end
                default: begin
                    load_stall = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu. Two instances (LOAD_LATENCY 1 and 3) share the
// ex_* stimulus; each step names which instance it checks. Expected per-cycle
// outputs are pushed to a scoreboard queue when the step is driven and popped at
// the falling edge of the cycle they belong to.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    typedef struct {
        string       tag;
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        stall;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wd;
        logic [31:0] pc;
        logic        adel;
        logic        ades;
        logic [31:0] bad;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        ex_valid;
    mem_op_e     ex_mem_op;
    logic [31:0] ex_addr;
    logic [31:0] ex_store_data;
    logic [31:0] ex_alu_result;
    logic        ex_wreg_en;
    logic [4:0]  ex_wreg_addr;
    logic [31:0] ex_pc;
    logic [31:0] rdata;

    logic        stall1, we1, adel1, ades1;
    logic [4:0]  wa1;
    logic [31:0] wd1, pc1, bad1;
    logic        stall3, we3, adel3, ades3;
    logic [4:0]  wa3;
    logic [31:0] wd3, pc3, bad3;

    int   n_checks = 0;
    int   n_err    = 0;
    obs_t exp_q[$];

    mem_lsu_if sram1();
    mem_lsu_if sram3();
    assign sram1.rdata = rdata;
    assign sram3.rdata = rdata;

    always #5 clk = ~clk;

    mem_lsu #(.LOAD_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush), .ex_valid(ex_valid), .ex_mem_op(ex_mem_op),
        .ex_addr(ex_addr), .ex_store_data(ex_store_data), .ex_alu_result(ex_alu_result),
        .ex_wreg_en(ex_wreg_en), .ex_wreg_addr(ex_wreg_addr), .ex_pc(ex_pc), .sram(sram1),
        .load_stall(stall1), .mem_regfile_write_enable(we1), .mem_regfile_write_addr(wa1),
        .mem_regfile_write_data(wd1), .mem_pc(pc1), .adel(adel1), .ades(ades1), .badvaddr(bad1)
    );

    mem_lsu #(.LOAD_LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst), .flush(flush), .ex_valid(ex_valid), .ex_mem_op(ex_mem_op),
        .ex_addr(ex_addr), .ex_store_data(ex_store_data), .ex_alu_result(ex_alu_result),
        .ex_wreg_en(ex_wreg_en), .ex_wreg_addr(ex_wreg_addr), .ex_pc(ex_pc), .sram(sram3),
        .load_stall(stall3), .mem_regfile_write_enable(we3), .mem_regfile_write_addr(wa3),
        .mem_regfile_write_data(wd3), .mem_pc(pc3), .adel(adel3), .ades(ades3), .badvaddr(bad3)
    );

    function automatic obs_t blank(string tag);
        obs_t o;
        o.tag = tag; o.en = 1'b0; o.wen = 4'h0; o.addr = 32'h0; o.wdata = 32'h0;
        o.stall = 1'b0; o.we = 1'b0; o.waddr = 5'h0; o.wd = 32'h0; o.pc = 32'h0;
        o.adel = 1'b0; o.ades = 1'b0; o.bad = 32'h0;
        return o;
    endfunction

    function automatic obs_t sample(int sel);
        obs_t o = blank("obs");
        if (sel == 1) begin
            o.en = sram1.en; o.wen = sram1.wen; o.addr = sram1.addr; o.wdata = sram1.wdata;
            o.stall = stall1; o.we = we1; o.waddr = wa1; o.wd = wd1; o.pc = pc1;
            o.adel = adel1; o.ades = ades1; o.bad = bad1;
        end else begin
            o.en = sram3.en; o.wen = sram3.wen; o.addr = sram3.addr; o.wdata = sram3.wdata;
            o.stall = stall3; o.we = we3; o.waddr = wa3; o.wd = wd3; o.pc = pc3;
            o.adel = adel3; o.ades = ades3; o.bad = bad3;
        end
        return o;
    endfunction

    // Reference load alignment, written lane by lane.
    function automatic logic [31:0] model_load(mem_op_e op, logic [1:0] off, logic [31:0] r);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = r[7:0];
            2'd1:    b = r[15:8];
            2'd2:    b = r[23:16];
            default: b = r[31:24];
        endcase
        h = off[1] ? r[31:16] : r[15:0];
        case (op)
            MEM_OP_LB:  return {{24{b[7]}}, b};
            MEM_OP_LBU: return {24'h0, b};
            MEM_OP_LH:  return {{16{h[15]}}, h};
            MEM_OP_LHU: return {16'h0, h};
            default:    return r;
        endcase
    endfunction

    // Reference outputs for one cycle seen by an idle unit (no reset, no flush).
    function automatic obs_t model_idle(string tag, logic valid, mem_op_e op, logic [31:0] a,
                                        logic [31:0] d, logic [31:0] alu, logic we,
                                        logic [4:0] wa, logic [31:0] pc);
        obs_t e = blank(tag);
        logic mis;
        logic ld;
        logic st;
        if (!valid) return e;
        ld  = (op == MEM_OP_LB || op == MEM_OP_LBU || op == MEM_OP_LH ||
               op == MEM_OP_LHU || op == MEM_OP_LW);
        st  = (op == MEM_OP_SB || op == MEM_OP_SH || op == MEM_OP_SW);
        mis = ((op == MEM_OP_LH || op == MEM_OP_LHU || op == MEM_OP_SH) && a[0]) ||
              ((op == MEM_OP_LW || op == MEM_OP_SW) && a[1:0] != 2'b00);
        e.pc = pc;
        if (mis) begin
            e.adel = ld; e.ades = st; e.bad = a;
        end else if (ld) begin
            e.en = 1'b1; e.addr = {a[31:2], 2'b00}; e.stall = 1'b1;
        end else if (st) begin
            e.en = 1'b1; e.addr = {a[31:2], 2'b00};
            case (op)
                MEM_OP_SB: begin
                    case (a[1:0])
                        2'd0:    e.wen = 4'b0001;
                        2'd1:    e.wen = 4'b0010;
                        2'd2:    e.wen = 4'b0100;
                        default: e.wen = 4'b1000;
                    endcase
                    e.wdata = {d[7:0], d[7:0], d[7:0], d[7:0]};
                end
                MEM_OP_SH: begin
                    e.wen   = a[1] ? 4'b1100 : 4'b0011;
                    e.wdata = {d[15:0], d[15:0]};
                end
                default: begin
                    e.wen = 4'b1111; e.wdata = d;
                end
            endcase
        end else begin
            e.we = we; e.waddr = wa; e.wd = alu;
        end
        return e;
    endfunction

    task automatic chk(string tag, string field, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
        end
    endtask

    // Pop the expectation for this cycle, compare at the falling edge, then step past the next rising edge.
    task automatic check_cycle(int sel);
        obs_t e;
        obs_t o;
        @(negedge clk);
        n_checks++;
        assert (exp_q.size() != 0) else begin
            n_err++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = sample(sel);
            chk(e.tag, "en", o.en, e.en);
            chk(e.tag, "wen", o.wen, e.wen);
            chk(e.tag, "addr", o.addr, e.addr);
            chk(e.tag, "wdata", o.wdata, e.wdata);
            chk(e.tag, "stall", o.stall, e.stall);
            chk(e.tag, "we", o.we, e.we);
            chk(e.tag, "waddr", o.waddr, e.waddr);
            chk(e.tag, "wd", o.wd, e.wd);
            chk(e.tag, "pc", o.pc, e.pc);
            chk(e.tag, "adel", o.adel, e.adel);
            chk(e.tag, "ades", o.ades, e.ades);
            chk(e.tag, "badvaddr", o.bad, e.bad);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(logic valid, mem_op_e op, logic [31:0] a, logic [31:0] d,
                          logic [31:0] alu, logic we, logic [4:0] wa, logic [31:0] pc);
        ex_valid = valid; ex_mem_op = op; ex_addr = a; ex_store_data = d;
        ex_alu_result = alu; ex_wreg_en = we; ex_wreg_addr = wa; ex_pc = pc;
    endtask

    // One single-cycle step on an idle unit.
    task automatic run_one(int sel, string tag, logic valid, mem_op_e op, logic [31:0] a,
                           logic [31:0] d, logic [31:0] alu, logic we, logic [4:0] wa,
                           logic [31:0] pc);
        set_ex(valid, op, a, d, alu, we, wa, pc);
        exp_q.push_back(model_idle(tag, valid, op, a, d, alu, we, wa, pc));
        check_cycle(sel);
    endtask

    // A full load: issue, lat-1 stall cycles, then retirement with rd on the bus.
    task automatic run_load(int sel, int lat, string tag, mem_op_e op, logic [31:0] a,
                            logic [4:0] wa, logic [31:0] pc, logic [31:0] rd);
        obs_t e;
        set_ex(1'b1, op, a, 32'h0, 32'h0, 1'b1, wa, pc);
        exp_q.push_back(model_idle({tag, "_issue"}, 1'b1, op, a, 32'h0, 32'h0, 1'b1, wa, pc));
        for (int i = 1; i < lat; i++) begin
            e = blank({tag, "_wait"});
            e.stall = 1'b1;
            exp_q.push_back(e);
        end
        e = blank({tag, "_done"});
        e.we = 1'b1; e.waddr = wa; e.wd = model_load(op, a[1:0], rd); e.pc = pc;
        exp_q.push_back(e);
        for (int i = 0; i <= lat; i++) begin
            rdata = (i == lat) ? rd : (32'hDEAD0000 ^ 32'(i));
            check_cycle(sel);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; rdata = 32'h0;
        set_ex(1'b1, MEM_OP_LW, 32'h100, 32'h0, 32'h0, 1'b1, 5'd1, 32'h400);

        // Reset silences both instances even with a valid load presented.
        exp_q.push_back(blank("rst_dut1"));
        check_cycle(1);
        exp_q.push_back(blank("rst_dut3"));
        check_cycle(3);
        rst = 1'b0;

        run_one(1, "idle_invalid", 1'b0, MEM_OP_SW, 32'h100, 32'h1, 32'h2, 1'b1, 5'd3, 32'h404);
        run_one(1, "sw", 1'b1, MEM_OP_SW, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 5'd0, 32'h400);
        run_one(1, "sb_103", 1'b1, MEM_OP_SB, 32'h103, 32'h000000AB, 32'h0, 1'b0, 5'd0, 32'h404);
        run_one(1, "sh_102", 1'b1, MEM_OP_SH, 32'h102, 32'h00001234, 32'h0, 1'b0, 5'd0, 32'h408);
        run_one(1, "sh_100", 1'b1, MEM_OP_SH, 32'h100, 32'hFFFF5678, 32'h0, 1'b0, 5'd0, 32'h40C);
        for (int k = 0; k < 4; k++)
            run_one(1, "sb_lane", 1'b1, MEM_OP_SB, 32'h140 + 32'(k), 32'h1234565A, 32'h0, 1'b0,
                    5'd0, 32'h420 + 32'(4 * k));
        run_one(1, "alu_pass", 1'b1, MEM_OP_NONE, 32'h0, 32'h0, 32'h00000055, 1'b1, 5'd7, 32'h430);
        run_one(1, "alu_r0", 1'b1, MEM_OP_NONE, 32'h0, 32'h0, 32'h12345678, 1'b1, 5'd0, 32'h434);

        run_load(1, 1, "lb_neg", MEM_OP_LB, 32'h102, 5'd9, 32'h410, 32'h12803456);
        run_load(1, 1, "lbu", MEM_OP_LBU, 32'h102, 5'd10, 32'h414, 32'h12803456);
        for (int k = 0; k < 4; k++)
            run_load(1, 1, "lb_off", MEM_OP_LB, 32'h180 + 32'(k), 5'd11, 32'h440, 32'h80FF7F01);
        run_load(1, 1, "lh_hi", MEM_OP_LH, 32'h102, 5'd12, 32'h450, 32'h80123456);
        run_load(1, 1, "lhu_lo", MEM_OP_LHU, 32'h100, 5'd13, 32'h454, 32'h1234F00F);
        run_load(1, 1, "lw", MEM_OP_LW, 32'h104, 5'd14, 32'h458, 32'h13579BDF);

        run_one(1, "lw_adel", 1'b1, MEM_OP_LW, 32'h102, 32'h0, 32'h0, 1'b1, 5'd2, 32'h460);
        run_one(1, "sh_ades", 1'b1, MEM_OP_SH, 32'h101, 32'h1234, 32'h0, 1'b0, 5'd0, 32'h464);
        run_one(1, "sw_ades", 1'b1, MEM_OP_SW, 32'h103, 32'h1234, 32'h0, 1'b0, 5'd0, 32'h468);
        run_one(1, "lhu_adel", 1'b1, MEM_OP_LHU, 32'h103, 32'h0, 32'h0, 1'b1, 5'd2, 32'h46C);

        // A flushed store never strobes the SRAM.
        flush = 1'b1;
        set_ex(1'b1, MEM_OP_SW, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 5'd0, 32'h470);
        exp_q.push_back(blank("flush_store"));
        check_cycle(1);
        flush = 1'b0;

        // Reset the long-latency instance, then a three-cycle load.
        rst = 1'b1;
        exp_q.push_back(blank("rst_dut3_again"));
        check_cycle(3);
        rst = 1'b0;
        run_load(3, 3, "lw_lat3", MEM_OP_LW, 32'h200, 5'd3, 32'h500, 32'hCAFEF00D);
        run_one(3, "lat3_idle", 1'b0, MEM_OP_NONE, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Flush one cycle into a three-cycle load; the next load issues normally.
        set_ex(1'b1, MEM_OP_LW, 32'h200, 32'h0, 32'h0, 1'b1, 5'd3, 32'h500);
        exp_q.push_back(model_idle("flush_issue", 1'b1, MEM_OP_LW, 32'h200, 32'h0, 32'h0,
                                   1'b1, 5'd3, 32'h500));
        check_cycle(3);
        flush = 1'b1;
        exp_q.push_back(blank("flush_wait"));
        check_cycle(3);
        flush = 1'b0;
        run_load(3, 3, "after_flush", MEM_OP_LW, 32'h204, 5'd4, 32'h508, 32'h11112222);

        // Same again with reset cutting the load short.
        set_ex(1'b1, MEM_OP_LW, 32'h300, 32'h0, 32'h0, 1'b1, 5'd6, 32'h5F0);
        exp_q.push_back(model_idle("rst_issue", 1'b1, MEM_OP_LW, 32'h300, 32'h0, 32'h0,
                                   1'b1, 5'd6, 32'h5F0));
        check_cycle(3);
        rst = 1'b1;
        exp_q.push_back(blank("rst_wait"));
        check_cycle(3);
        rst = 1'b0;
        run_load(3, 3, "after_rst", MEM_OP_LH, 32'h302, 5'd5, 32'h600, 32'h7FFF0000);

        n_checks++;
        assert (exp_q.size() == 0) else begin
            n_err++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
